// File: rtl/bp_cfg_sequencer.sv
// Post-reset configuration sequencer: walks every core, issues its config writes, then unfreezes all cores.
// Optional macro BP_CFG_SEQ_STALL_CNT_EN adds a saturating 16-bit stall cycle counter output.
module bp_cfg_sequencer #(
    parameter int num_core_p       = 1,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int core_id_width_p  = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        cce_mode_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_id_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef BP_CFG_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONFIG   = 2'd1,
        UNFREEZE = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [core_id_width_p-1:0] core_q, core_d;
    logic [2:0]                 step_q, step_d;
    logic                       mode_q, mode_d;

    logic                       hs;
    logic                       last_core;
    logic                       start_ok;
    logic [core_id_width_p:0]   core_dbl;

    assign hs        = cfg_v_o & cfg_ready_i;
    assign last_core = (core_q == core_id_width_p'(num_core_p - 1));
    assign start_ok  = start_i & ((state_q == IDLE) | (state_q == DONE));
    assign core_dbl  = {core_q, 1'b0};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            core_q  <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        step_d  = step_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    mode_d  = cce_mode_i;
                    core_d  = '0;
                    step_d  = '0;
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                if (hs) begin
                    if (step_q == 3'd5) begin
                        step_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = UNFREEZE;
                        end else begin
                            core_d = core_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            UNFREEZE: begin
                if (hs) begin
                    if (last_core) begin
                        core_d  = '0;
                        state_d = DONE;
                    end else begin
                        core_d = core_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only registered state, so the payload holds while stalled.
    always_comb begin
        cfg_v_o    = 1'b0;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        busy_o     = 1'b0;
        done_o     = (state_q == DONE);
        if (state_q == CONFIG) begin
            cfg_v_o    = 1'b1;
            busy_o     = 1'b1;
            cfg_core_o = core_q;
            cfg_addr_o = cfg_addr_width_p'(step_q + 3'd1);
            case (step_q)
                3'd0:    cfg_data_o = cfg_data_width_p'(1);
                3'd1:    cfg_data_o = cfg_data_width_p'(core_q);
                3'd2:    cfg_data_o = cfg_data_width_p'(core_dbl);
                3'd3:    cfg_data_o = cfg_data_width_p'(core_dbl | 1'b1);
                3'd4:    cfg_data_o = cfg_data_width_p'(core_q);
                default: cfg_data_o = cfg_data_width_p'(mode_q);
            endcase
        end else if (state_q == UNFREEZE) begin
            cfg_v_o    = 1'b1;
            busy_o     = 1'b1;
            cfg_core_o = core_q;
            cfg_addr_o = cfg_addr_width_p'(1);
            cfg_data_o = '0;
        end
    end

`ifdef BP_CFG_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || start_ok) begin
            stall_q <= '0;
        end else if (cfg_v_o && !cfg_ready_i && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// Directed bench for bp_cfg_sequencer: a 1-core and a 4-core instance checked against a write-list model.
module tb_bp_cfg_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // single-core instance
    logic        start1 = 1'b0, mode1 = 1'b0, rdy1 = 1'b0;
    logic        v1, busy1, done1;
    logic [0:0]  core1;
    logic [15:0] addr1;
    logic [31:0] data1;

    // four-core instance
    logic        start4 = 1'b0, mode4 = 1'b0, rdy4 = 1'b0;
    logic        v4, busy4, done4;
    logic [1:0]  core4;
    logic [15:0] addr4;
    logic [31:0] data4;
`ifdef BP_CFG_SEQ_STALL_CNT_EN
    logic [15:0] stall1, stall4;
`endif

    bp_cfg_sequencer #(.num_core_p(1)) dut1 (
        .clk_i(clk), .reset_i(rst), .start_i(start1), .cce_mode_i(mode1),
        .cfg_v_o(v1), .cfg_ready_i(rdy1), .cfg_core_o(core1), .cfg_addr_o(addr1),
        .cfg_data_o(data1), .busy_o(busy1), .done_o(done1)
`ifdef BP_CFG_SEQ_STALL_CNT_EN
        , .stall_cnt_o(stall1)
`endif
    );

    bp_cfg_sequencer #(.num_core_p(4)) dut4 (
        .clk_i(clk), .reset_i(rst), .start_i(start4), .cce_mode_i(mode4),
        .cfg_v_o(v4), .cfg_ready_i(rdy4), .cfg_core_o(core4), .cfg_addr_o(addr4),
        .cfg_data_o(data4), .busy_o(busy4), .done_o(done4)
`ifdef BP_CFG_SEQ_STALL_CNT_EN
        , .stall_cnt_o(stall4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write k of a pass over n cores: 6 config writes per core, then one unfreeze per core.
    task automatic exp_write(input int k, input int n, input logic m,
                             output int core, output int addr, output int data);
        int s;
        if (k < 6 * n) begin
            core = k / 6;
            s    = k % 6;
            addr = s + 1;
            case (s)
                0:       data = 1;
                1:       data = core;
                2:       data = 2 * core;
                3:       data = 2 * core + 1;
                4:       data = core;
                default: data = int'(m);
            endcase
        end else begin
            core = k - 6 * n;
            addr = 1;
            data = 0;
        end
    endtask

    // One pass on the 4-core instance; pct = ready duty in percent, glitch_at = cycle of a
    // stray start with toggled mode, abort_at = write index at which reset is asserted.
    task automatic run4(input logic m, input int pct, input int glitch_at, input int abort_at);
        int k = 0, stall = 0, cyc = 0, last_hs = -10;
        int ec, ea, ed;
        @(negedge clk);
        start4 = 1'b1;
        mode4  = m;
        @(negedge clk);
        start4 = 1'b0;
        check("start_clears_done", done4, 0);
        check("start_sets_busy", busy4, 1);
        while (!done4 && cyc < 2000) begin
            check("busy_eq_valid", busy4, v4);
            if (cyc == glitch_at) begin
                start4 = 1'b1;
                mode4  = ~m;
            end else begin
                start4 = 1'b0;
            end
            if (abort_at >= 0 && k == abort_at && v4) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_valid", v4, 0);
                check("abort_busy", busy4, 0);
                check("abort_done", done4, 0);
                $display("abort at write %0d", k);
                return;
            end
            if (v4) begin
                exp_write(k, 4, m, ec, ea, ed);
                check("core", core4, ec);
                check("addr", addr4, ea);
                check("data", data4, ed);
            end
            rdy4 = (pct >= 100) || ($urandom_range(0, 99) < pct);
            if (v4 && rdy4) begin
                $display("write %0d core=%0d addr=%0h data=%0h", k, core4, addr4, data4);
                k++;
                last_hs = cyc;
            end
            if (v4 && !rdy4) stall++;
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        check("pass_completes", done4, 1);
        check("write_count", k, 28);
        check("done_latency", cyc - last_hs, 1);
        check("done_valid_low", v4, 0);
        check("done_busy_low", busy4, 0);
`ifdef BP_CFG_SEQ_STALL_CNT_EN
        check("stall_cnt", stall4, stall);
`endif
        $display("pass mode=%0d ready=%0d%% stalls=%0d cycles=%0d", m, pct, stall, cyc);
    endtask

    initial begin
        int ec, ea, ed;
        repeat (3) @(negedge clk);
        check("rst_v1", v1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_v4", v4, 0);
        check("rst_busy4", busy4, 0);
        check("rst_done4", done4, 0);
        check("rst_addr4", addr4, 0);
        check("rst_data4", data4, 0);
        check("rst_core4", core4, 0);
        rst = 1'b0;

        // single core, ready held high: seven back-to-back writes, done on cycle 8
        @(negedge clk);
        start1 = 1'b1;
        mode1  = 1'b1;
        rdy1   = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_write(i, 1, 1'b1, ec, ea, ed);
            check("n1_busy", busy1, 1);
            check("n1_valid", v1, 1);
            check("n1_core", core1, ec);
            check("n1_addr", addr1, ea);
            check("n1_data", data1, ed);
            $display("n1 write %0d addr=%0h data=%0h", i, addr1, data1);
            @(negedge clk);
        end
        check("n1_done", done1, 1);
        check("n1_busy_end", busy1, 0);
        check("n1_valid_end", v1, 0);

        run4(1'b1, 100, -1, -1);
        run4(1'b0, 50, 5, -1);
        run4(1'b1, 100, -1, 9);
        run4(1'b1, 100, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
